uart_ddr_cmd_parser: RTL



---
 rtl/uart_ddr_cmd_parser.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_ddr_cmd_parser.sv
// ASCII console command parser: turns "W <addr> <data>" and "R <addr>" lines into
// single-beat DDR app requests and streams the ASCII reply back to the UART.
module uart_ddr_cmd_parser #(
    parameter int ADDR_WIDTH  = 28,
    parameter int ADDR_DIGITS = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int RSP_TIMEOUT = 4096
) (
    input  logic                  ui_clk,
    input  logic                  resetn,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_byte,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_write,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  overrun
);

    localparam int TW = $clog2(RSP_TIMEOUT + 1);
    localparam logic [7:0]  CH_CR = 8'h0D;
    localparam logic [7:0]  CH_LF = 8'h0A;
    localparam logic [7:0]  CH_SP = 8'h20;
    localparam logic [79:0] RPL_E = {8'h45, 8'h0D, 8'h0A, 56'h0};
    localparam logic [79:0] RPL_K = {8'h4B, 8'h0D, 8'h0A, 56'h0};
    localparam logic [79:0] RPL_T = {8'h54, 8'h0D, 8'h0A, 56'h0};

    typedef enum logic [2:0] {
        S_CMD, S_SP, S_ADDR, S_DATA, S_SKIP, S_REQ, S_WAIT, S_TX
    } state_t;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    // Letters A-F / a-f carry their value minus 9 in the low nibble.
    function automatic logic [3:0] hex_val(input logic [7:0] b);
        return b[6] ? (b[3:0] + 4'd9) : b[3:0];
    endfunction

    function automatic logic [7:0] nib2asc(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [79:0] fmt_hex(input logic [DATA_WIDTH-1:0] d);
        logic [79:0] r;
        r = 80'h0;
        for (int i = 0; i < 8; i++) begin
            r[79-8*i -: 8] = nib2asc(d[DATA_WIDTH-1-4*i -: 4]);
        end
        r[15:0] = {CH_CR, CH_LF};
        return r;
    endfunction

    state_t                state_r, state_n;
    logic                  write_r, write_n;
    logic [3:0]            cnt_r, cnt_n;
    logic [ADDR_WIDTH-1:0] addr_r, addr_n;
    logic [DATA_WIDTH-1:0] data_r, data_n;
    logic [TW-1:0]         tmr_r, tmr_n;
    logic [79:0]           tx_buf_r, tx_buf_n;
    logic [3:0]            tx_len_r, tx_len_n;
    logic                  tx_valid_r, tx_valid_n;
    logic                  req_valid_r, req_valid_n;
    logic                  req_write_r, req_write_n;
    logic [ADDR_WIDTH-1:0] req_addr_r, req_addr_n;
    logic [DATA_WIDTH-1:0] req_wdata_r, req_wdata_n;
    logic                  overrun_r, overrun_n;
    logic                  err_s, rpl_s, fin_s, issue_s;
    logic [79:0]           reply_s;

    // Next-state and datapath decode for the parser, request and reply phases.
    always_comb begin
        state_n     = state_r;
        write_n     = write_r;
        cnt_n       = cnt_r;
        addr_n      = addr_r;
        data_n      = data_r;
        tmr_n       = tmr_r;
        tx_buf_n    = tx_buf_r;
        tx_len_n    = tx_len_r;
        tx_valid_n  = tx_valid_r;
        req_valid_n = req_valid_r;
        req_write_n = req_write_r;
        req_addr_n  = req_addr_r;
        req_wdata_n = req_wdata_r;
        overrun_n   = overrun_r;
        err_s       = 1'b0;
        rpl_s       = 1'b0;
        fin_s       = 1'b0;
        reply_s     = 80'h0;
        case (state_r)
            S_CMD: begin
                if (rx_valid) begin
                    if (rx_byte == 8'h57 || rx_byte == 8'h77) begin
                        write_n = 1'b1;
                        state_n = S_SP;
                    end else if (rx_byte == 8'h52 || rx_byte == 8'h72) begin
                        write_n = 1'b0;
                        state_n = S_SP;
                    end else if (rx_byte == CH_CR || rx_byte == CH_LF) begin
                        state_n = S_CMD;
                    end else begin
                        state_n = S_SKIP;
                    end
                end else begin
                    state_n = S_CMD;
                end
            end
            S_SP: begin
                if (rx_valid) begin
                    if (rx_byte == CH_SP) begin
                        addr_n  = {ADDR_WIDTH{1'b0}};
                        cnt_n   = 4'd0;
                        state_n = S_ADDR;
                    end else if (rx_byte == CH_CR) begin
                        err_s = 1'b1;
                    end else begin
                        state_n = S_SKIP;
                    end
                end else begin
                    state_n = S_SP;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    if (is_hex(rx_byte)) begin
                        if (cnt_r < 4'(ADDR_DIGITS)) begin
                            addr_n = {addr_r[ADDR_WIDTH-5:0], hex_val(rx_byte)};
                            cnt_n  = cnt_r + 4'd1;
                        end else begin
                            state_n = S_SKIP;
                        end
                    end else if (rx_byte == CH_SP) begin
                        if (write_r && cnt_r != 4'd0) begin
                            data_n  = {DATA_WIDTH{1'b0}};
                            cnt_n   = 4'd0;
                            state_n = S_DATA;
                        end else begin
                            state_n = S_SKIP;
                        end
                    end else if (rx_byte == CH_CR) begin
                        fin_s = !write_r && cnt_r != 4'd0;
                        err_s = write_r || cnt_r == 4'd0;
                    end else begin
                        state_n = S_SKIP;
                    end
                end else begin
                    state_n = S_ADDR;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (is_hex(rx_byte)) begin
                        if (cnt_r < 4'd8) begin
                            data_n = {data_r[DATA_WIDTH-5:0], hex_val(rx_byte)};
                            cnt_n  = cnt_r + 4'd1;
                        end else begin
                            state_n = S_SKIP;
                        end
                    end else if (rx_byte == CH_CR) begin
                        fin_s = cnt_r != 4'd0;
                        err_s = cnt_r == 4'd0;
                    end else begin
                        state_n = S_SKIP;
                    end
                end else begin
                    state_n = S_DATA;
                end
            end
            S_SKIP: begin
                err_s = rx_valid && rx_byte == CH_CR;
            end
            S_REQ: begin
                if (req_ready) begin
                    req_valid_n = 1'b0;
                    if (req_write_r) begin
                        rpl_s   = 1'b1;
                        reply_s = RPL_K;
                    end else begin
                        tmr_n   = {TW{1'b0}};
                        state_n = S_WAIT;
                    end
                end else begin
                    state_n = S_REQ;
                end
            end
            S_WAIT: begin
                // A response arriving on the expiry cycle still wins over the timeout.
                if (rsp_valid) begin
                    rpl_s   = 1'b1;
                    reply_s = fmt_hex(rsp_rdata);
                end else if (tmr_r == TW'(RSP_TIMEOUT - 1)) begin
                    rpl_s   = 1'b1;
                    reply_s = RPL_T;
                end else begin
                    tmr_n = tmr_r + TW'(1);
                end
            end
            S_TX: begin
                if (tx_ready) begin
                    tx_buf_n = {tx_buf_r[71:0], 8'h00};
                    if (tx_len_r == 4'd1) begin
                        tx_len_n   = 4'd0;
                        tx_valid_n = 1'b0;
                        state_n    = S_CMD;
                    end else begin
                        tx_len_n = tx_len_r - 4'd1;
                    end
                end else begin
                    state_n = S_TX;
                end
            end
            default: state_n = S_CMD;
        endcase

        // A complete line only becomes a request when the address is 8-byte aligned.
        issue_s = fin_s && addr_r[2:0] == 3'b000;
        err_s   = err_s || (fin_s && addr_r[2:0] != 3'b000);

        req_valid_n = issue_s ? 1'b1 : req_valid_n;
        req_write_n = issue_s ? write_r : req_write_n;
        req_addr_n  = issue_s ? addr_r : req_addr_n;
        req_wdata_n = issue_s ? (write_r ? data_r : {DATA_WIDTH{1'b0}}) : req_wdata_n;

        tx_buf_n   = err_s ? RPL_E : (rpl_s ? reply_s : tx_buf_n);
        tx_len_n   = err_s ? 4'd3 : (rpl_s ? (rsp_valid && state_r == S_WAIT ? 4'd10 : 4'd3) : tx_len_n);
        tx_valid_n = (err_s || rpl_s) ? 1'b1 : tx_valid_n;
        state_n    = (err_s || rpl_s) ? S_TX : (issue_s ? S_REQ : state_n);

        overrun_n = overrun_r ||
                    (rx_valid && (state_r == S_REQ || state_r == S_WAIT || state_r == S_TX));
    end

    // State and output registers; reset discards any partial command or reply.
    always_ff @(posedge ui_clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= S_CMD;
            write_r     <= 1'b0;
            cnt_r       <= 4'd0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            data_r      <= {DATA_WIDTH{1'b0}};
            tmr_r       <= {TW{1'b0}};
            tx_buf_r    <= 80'h0;
            tx_len_r    <= 4'd0;
            tx_valid_r  <= 1'b0;
            req_valid_r <= 1'b0;
            req_write_r <= 1'b0;
            req_addr_r  <= {ADDR_WIDTH{1'b0}};
            req_wdata_r <= {DATA_WIDTH{1'b0}};
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            write_r     <= write_n;
            cnt_r       <= cnt_n;
            addr_r      <= addr_n;
            data_r      <= data_n;
            tmr_r       <= tmr_n;
            tx_buf_r    <= tx_buf_n;
            tx_len_r    <= tx_len_n;
            tx_valid_r  <= tx_valid_n;
            req_valid_r <= req_valid_n;
            req_write_r <= req_write_n;
            req_addr_r  <= req_addr_n;
            req_wdata_r <= req_wdata_n;
            overrun_r   <= overrun_n;
        end
    end

    assign tx_valid  = tx_valid_r;
    assign tx_byte   = tx_buf_r[79:72];
    assign req_valid = req_valid_r;
    assign req_write = req_write_r;
    assign req_addr  = req_addr_r;
    assign req_wdata = req_wdata_r;
    assign overrun   = overrun_r;

endmodule
